// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// State encodings are fixed so that waveforms and external probes agree
// with the rest of the CPU codebase. WORD_SIZE_DEFAULT mirrors the
// machine word width used across the datapath.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEFAULT    = 16;
  localparam int STARVE_LIMIT_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_I_RD = 2'd1,
    ST_D_RD = 2'd2,
    ST_D_WR = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_bus_driver.sv
// Write-data register plus tri-state driver for the shared memory data bus.
// Latency: wdata captured on the edge where load=1; bus follows oe combinationally.
// Backpressure: none; the owner decides when to load and when to drive.
//
// Ports:
//   clk, reset_n : clock and async active-low reset
//   load         : capture wdata into the write-data register
//   oe           : drive the register onto data, otherwise release to high-Z
//   wdata        : write data to capture
//   data         : shared bidirectional memory data bus
module mem_bus_driver #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 oe,
  input  logic [WORD_SIZE-1:0] wdata,
  inout  wire  [WORD_SIZE-1:0] data
);

  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] wdata_d;

  always_comb begin
    wdata_d = wdata_q;
    if (load) begin
      wdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdata_q <= '0;
    end else begin
      wdata_q <= wdata_d;
    end
  end

  assign data = oe ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single memory port between instruction fetch and data access.
// Latency: strobe rises on the grant edge; done pulses the cycle after the handshake edge (min 2 cycles).
// Backpressure: one transaction at a time; requesters hold their request until done.
//
// Ports:
//   clk, reset_n                      : clock and async active-low reset
//   i_req/i_addr -> i_done/i_rdata    : fetch read requester
//   d_read/d_write/d_addr/d_wdata
//     -> d_done/d_rdata               : data access requester
//   readM/writeM/address/data         : shared memory port
//   inputReady/ackOutput              : memory read-valid / write-accept handshakes
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT data grants
// won while fetch was waiting, the next grant is forced to fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_done,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  arb_state_e           state_q, state_d;
  logic                 readm_q, readm_d;
  logic                 writem_q, writem_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 wdata_load;
  logic                 grant_i;
  logic                 grant_d;
  logic                 fetch_force;

  // Grant and transaction sequencing. Handshakes are only looked at in the
  // busy states, so a handshake that is already high when the strobe rises
  // is honoured one edge later, and stray handshakes in IDLE do nothing.
  always_comb begin
    state_d    = state_q;
    readm_d    = readm_q;
    writem_d   = writem_q;
    addr_d     = addr_q;
    i_done_d   = 1'b0;
    d_done_d   = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    wdata_load = 1'b0;
    grant_i    = 1'b0;
    grant_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_force && i_req) begin
          grant_i = 1'b1;
          addr_d  = i_addr;
          readm_d = 1'b1;
          state_d = ST_I_RD;
        end else if (d_write) begin
          // A simultaneous d_read is dropped: the write wins outright.
          grant_d    = 1'b1;
          addr_d     = d_addr;
          writem_d   = 1'b1;
          wdata_load = 1'b1;
          state_d    = ST_D_WR;
        end else if (d_read) begin
          grant_d = 1'b1;
          addr_d  = d_addr;
          readm_d = 1'b1;
          state_d = ST_D_RD;
        end else if (i_req) begin
          grant_i = 1'b1;
          addr_d  = i_addr;
          readm_d = 1'b1;
          state_d = ST_I_RD;
        end
      end
      ST_I_RD: begin
        if (inputReady) begin
          i_rdata_d = data;
          readm_d   = 1'b0;
          i_done_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_D_RD: begin
        if (inputReady) begin
          d_rdata_d = data;
          readm_d   = 1'b0;
          d_done_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_D_WR: begin
        if (ackOutput) begin
          writem_d = 1'b0;
          d_done_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      readm_q   <= 1'b0;
      writem_q  <= 1'b0;
      addr_q    <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      readm_q   <= readm_d;
      writem_q  <= writem_d;
      addr_q    <= addr_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign fetch_force = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && i_req && !fetch_force) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_force = 1'b0;
`endif

  // Bus drive follows the registered write strobe, so it is released on the
  // same edge that clears writeM and drops immediately on reset.
  mem_bus_driver #(
    .WORD_SIZE (WORD_SIZE)
  ) u_bus_driver (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (wdata_load),
    .oe      (writem_q),
    .wdata   (d_wdata),
    .data    (data)
  );

  assign readM   = readm_q;
  assign writeM  = writem_q;
  assign address = addr_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Inputs change and outputs are sampled 1 time unit after each posedge.
// The data bus has pull-ups, so a released bus reads as all ones.
module tb_mem_port_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_req;
  logic [W-1:0] i_addr;
  logic         i_done;
  logic [W-1:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_done;
  logic [W-1:0] d_rdata;
  logic         readM;
  logic         writeM;
  logic [W-1:0] address;
  wire  [W-1:0] data;
  logic         inputReady;
  logic         ackOutput;

  logic         mem_drv;
  logic [W-1:0] mem_val;

  int n_checks = 0;
  int n_fail   = 0;

  assign data = mem_drv ? mem_val : {W{1'bz}};

  for (genvar g = 0; g < W; g++) begin : g_pu
    pullup (data[g]);
  end

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_SIZE    (W),
    .STARVE_LIMIT (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_done     (i_done),
    .i_rdata    (i_rdata),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .ackOutput  (ackOutput)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_answer(input logic [W-1:0] val);
    inputReady = 1'b1;
    mem_drv    = 1'b1;
    mem_val    = val;
  endtask

  task automatic mem_quiet();
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_drv    = 1'b0;
  endtask

  initial begin
    i_req      = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_drv    = 1'b0;
    mem_val    = '0;
    reset_n    = 1'b1;
    #2 reset_n = 1'b0;
    #20;

    // Reset state
    check_eq("rst_readM",   readM,   0);
    check_eq("rst_writeM",  writeM,  0);
    check_eq("rst_address", address, 0);
    check_eq("rst_data_z",  data,    32'hFFFF);
    check_eq("rst_i_done",  i_done,  0);
    check_eq("rst_d_done",  d_done,  0);
    check_eq("rst_i_rdata", i_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("idle_readM", readM, 0);

    // Handshakes while IDLE are ignored
    mem_answer(16'hDEAD);
    ackOutput = 1'b1;
    tick();
    check_eq("idle_hs_i_done", i_done,  0);
    check_eq("idle_hs_d_done", d_done,  0);
    check_eq("idle_hs_rdata",  i_rdata, 0);
    mem_quiet();
    tick();

    // Fetch only: memory answers after two cycles
    i_req  = 1'b1;
    i_addr = 16'h0004;
    tick();
    check_eq("f_readM0",  readM,   1);
    check_eq("f_addr",    address, 16'h0004);
    check_eq("f_writeM",  writeM,  0);
    tick();
    check_eq("f_readM1",  readM,   1);
    tick();
    check_eq("f_readM2",  readM,   1);
    check_eq("f_nodone",  i_done,  0);
    mem_answer(16'hA5F0);
    tick();
    check_eq("f_readM_off", readM,   0);
    check_eq("f_i_done",    i_done,  1);
    check_eq("f_i_rdata",   i_rdata, 16'hA5F0);
    check_eq("f_d_done",    d_done,  0);
    i_req = 1'b0;
    mem_quiet();
    tick();
    check_eq("f_i_done_1cyc", i_done,  0);
    check_eq("f_readM_after", readM,   0);
    check_eq("f_rdata_hold",  i_rdata, 16'hA5F0);

    // Collision: data read first, then fetch after one IDLE bubble
    i_req  = 1'b1;
    i_addr = 16'h0008;
    d_read = 1'b1;
    d_addr = 16'h0020;
    tick();
    check_eq("c_readM",  readM,   1);
    check_eq("c_addr_d", address, 16'h0020);
    mem_answer(16'h1234);
    tick();
    check_eq("c_d_done",  d_done,  1);
    check_eq("c_i_done0", i_done,  0);
    check_eq("c_d_rdata", d_rdata, 16'h1234);
    check_eq("c_bubble",  readM,   0);
    d_read = 1'b0;
    mem_quiet();
    tick();
    check_eq("c_addr_i",   address, 16'h0008);
    check_eq("c_readM_i",  readM,   1);
    check_eq("c_d_done_1", d_done,  0);
    // Fetch drops its request mid-transaction; it still completes.
    i_req = 1'b0;
    mem_answer(16'h5555);
    tick();
    check_eq("c_i_done",  i_done,  1);
    check_eq("c_i_rdata", i_rdata, 16'h5555);
    check_eq("c_d_hold",  d_rdata, 16'h1234);
    mem_quiet();
    tick();

    // Write with ack one cycle after the strobe
    d_write = 1'b1;
    d_addr  = 16'h0030;
    d_wdata = 16'hBEEF;
    tick();
    check_eq("w_writeM", writeM,  1);
    check_eq("w_addr",   address, 16'h0030);
    check_eq("w_data",   data,    16'hBEEF);
    check_eq("w_readM",  readM,   0);
    tick();
    check_eq("w_hold",   data,    16'hBEEF);
    ackOutput = 1'b1;
    tick();
    check_eq("w_writeM_off", writeM, 0);
    check_eq("w_data_z",     data,   32'hFFFF);
    check_eq("w_d_done",     d_done, 1);
    d_write = 1'b0;
    mem_quiet();
    tick();
    check_eq("w_d_done_1cyc", d_done, 0);

    // Read and write together: handled as a write
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 16'h0060;
    d_wdata = 16'h1357;
    tick();
    check_eq("rw_writeM", writeM, 1);
    check_eq("rw_readM",  readM,  0);
    check_eq("rw_data",   data,   16'h1357);
    ackOutput = 1'b1;
    tick();
    check_eq("rw_d_done",  d_done,  1);
    check_eq("rw_readM2",  readM,   0);
    check_eq("rw_rdata",   d_rdata, 16'h1234);
    d_read  = 1'b0;
    d_write = 1'b0;
    mem_quiet();
    tick();

    // Reset in the middle of a data read
    d_read = 1'b1;
    d_addr = 16'h0050;
    tick();
    check_eq("r_readM_pre", readM, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("r_readM",   readM,   0);
    check_eq("r_address", address, 0);
    check_eq("r_data_z",  data,    32'hFFFF);
    check_eq("r_d_done",  d_done,  0);
    check_eq("r_d_rdata", d_rdata, 0);
    d_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("r_idle_readM", readM,  0);
    check_eq("r_no_done",    d_done, 0);

    // Continuous data reads with a waiting fetch
    i_req  = 1'b1;
    i_addr = 16'h0080;
    d_read = 1'b1;
    d_addr = 16'h0070;
    for (int g = 0; g < 5; g++) begin
      logic fetch_turn;
`ifdef ARB_STARVE_GUARD_EN
      fetch_turn = (g == 3);
`else
      fetch_turn = 1'b0;
`endif
      tick();
      check_eq($sformatf("s_readM_%0d", g), readM, 1);
      check_eq($sformatf("s_addr_%0d", g), address, fetch_turn ? 16'h0080 : 16'h0070);
      mem_answer(16'h0100 + 16'(g));
      tick();
      check_eq($sformatf("s_done_%0d", g), {i_done, d_done}, fetch_turn ? 2'b10 : 2'b01);
      mem_quiet();
    end
    i_req  = 1'b0;
    d_read = 1'b0;
    tick();
    tick();
    check_eq("end_idle", readM, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port (readM/writeM/address/data with inputReady/ackOutput handshake) between two requesters: instruction fetch (i_*) and data access (d_*).
- Sits between the CPU datapath (fetch unit, memory stage) and the external memory model.
- Runs one transaction at a time, latches read data, and pulses a per-requester done.
- Replaces ad-hoc clk-edge splitting of fetch and data access with an explicit FSM.

Parameters:
- WORD_SIZE, 16, address/data width (matches `WORD_SIZE in opcodes.v).
- STARVE_LIMIT, 3, consecutive lost fetch arbitrations before fetch is forced ahead (optional feature only).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- i_req  input  1  fetch read request; held high until i_done.
- i_addr  input  WORD_SIZE  fetch address; stable while i_req.
- i_done  output  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  output  WORD_SIZE  fetched instruction word; holds until the next fetch completes.
- d_read  input  1  data read request; held until d_done.
- d_write  input  1  data write request; held until d_done.
- d_addr  input  WORD_SIZE  data address.
- d_wdata  input  WORD_SIZE  write data.
- d_done  output  1  one-cycle pulse: data access complete.
- d_rdata  output  WORD_SIZE  read data; holds until the next data read completes.
- readM  output  1  memory read strobe.
- writeM  output  1  memory write strobe.
- address  output  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  driven with the latched write data while writeM=1, else high-Z.
- inputReady  input  1  memory read data valid on data.
- ackOutput  input  1  memory has accepted the write.

Behaviour:
- Reset (async, immediate): state IDLE; readM=0, writeM=0, address=0, data=Z, i_done=0, d_done=0, i_rdata=0, d_rdata=0. An in-flight transaction is dropped; requesters must reissue it.
- All outputs except data are registered.
- FSM states: IDLE, I_RD, D_RD, D_WR.
- IDLE:
  - Priority at posedge: d_write > d_read > i_req. The data stage is older in the pipeline and must not stall behind fetch.
  - Chosen access: load address, plus the write-data register for D_WR; set readM or writeM; enter I_RD, D_RD or D_WR.
  - d_read and d_write both high: treated as a write, and the read is ignored.
- I_RD / D_RD: hold readM and address. On a posedge with inputReady=1: latch data into i_rdata/d_rdata, clear readM, pulse i_done/d_done for the next cycle, return to IDLE.
- D_WR: hold writeM, address and bus drive. On a posedge with ackOutput=1: clear writeM, release bus the same edge, pulse d_done, return to IDLE.
- Latency: request seen in IDLE at edge N; strobe high from N; completion at the first edge M with the handshake high; done high in cycle M..M+1. Minimum 2 cycles from request to done. One IDLE bubble between back-to-back transactions.
- Handshake arriving in the same cycle the strobe rises: honoured at the next edge, never earlier.
- inputReady/ackOutput while IDLE: ignored.
- Requester deasserting its request mid-transaction: the transaction still completes and done still pulses.
- done pulses are exactly one cycle even if the request stays high. The requester must drop its request the cycle after done, or it is re-served.
- The address register is not modified outside IDLE.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating counter (width clog2(STARVE_LIMIT+1)) increments each time IDLE grants a data access while i_req=1, and clears on any fetch grant or reset.
  - When it reaches STARVE_LIMIT, the next IDLE grant goes to fetch regardless of data requests.
- Undefined: strict fixed priority; the counter logic is absent.

Decomposition:
- Shared package/header:
  - FSM state encodings: ST_IDLE=2'd0, ST_I_RD=2'd1, ST_D_RD=2'd2, ST_D_WR=2'd3.
  - WORD_SIZE reused from opcodes.v.
- Sub-module mem_bus_driver: tri-state data driver plus write-data register (inputs clk, reset_n, load, oe, wdata).
- The FSM and grant logic stay in the top module.

Test Plan:
- Fetch only: i_req=1, i_addr=16'h0004; memory answers inputReady after 2 cycles with 16'hA5F0 -> readM high for 3 cycles, address=4, i_rdata=16'hA5F0, single i_done pulse, readM=0 after.
- Collision: i_req and d_read asserted same edge (d_addr=16'h0020, mem returns 16'h1234) -> data served first, d_done then i_done, d_rdata=16'h1234, fetch address issued after one IDLE bubble.
- Write: d_write=1, d_addr=16'h0030, d_wdata=16'hBEEF, ackOutput after 1 cycle -> writeM high, data=16'hBEEF while writeM, data=Z after ack, one d_done pulse.
- Reset mid-read: assert reset_n=0 while in D_RD -> readM=0 and data=Z immediately, no d_done, FSM IDLE after release.
- d_read=d_write=1 -> write performed, readM never asserted.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=3: continuous d_read plus i_req -> after 3 data grants the 4th grant is fetch. Without the macro, fetch is never granted.
